// File: rtl/signed_mult_seq.sv
// Sequential shift-add multiplier, signed (two's complement) or unsigned.
// Product is {Aval,Bval}; X is the sign/carry extension of A.
`timescale 1ns/1ps
module signed_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  // state | meaning
  // IDLE  | waiting; ClearA_LoadB loads B, Run starts a multiply
  // ADD   | conditionally add (or subtract on last signed step) M into {X,A}
  // SHIFT | shift {X,A,B} right one bit, advance iteration counter
  // HOLD  | result stable until Run is released
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic             mode;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   xa;
  logic [WIDTH:0]   add_res;

  always_comb begin
    m_ext = mode ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    xa    = mode ? {X, Aval} : {1'b0, Aval};
    // Signed multiplier MSB carries negative weight, hence the final subtract.
    if (mode && (cnt == LAST))
      add_res = xa - m_ext;
    else
      add_res = xa + m_ext;
  end

  assign Busy = (state == ADD) || (state == SHIFT);
  assign Done = (state == HOLD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Aval  <= '0;
      Bval  <= '0;
      X     <= 1'b0;
      m_reg <= '0;
      mode  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            Aval <= '0;
            X    <= 1'b0;
            Bval <= S;
          end else if (Run) begin
            m_reg <= S;
            mode  <= Signed;
            Aval  <= '0;
            X     <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          if (Bval[0]) begin
            X    <= add_res[WIDTH];
            Aval <= add_res[WIDTH-1:0];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          Aval <= {X, Aval[WIDTH-1:1]};
          Bval <= {Aval[0], Bval[WIDTH-1:1]};
          if (!mode) X <= 1'b0;
          cnt <= cnt + CW'(1);
          state <= (cnt == LAST) ? HOLD : ADD;
        end
        HOLD: begin
          if (!Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mult_seq.sv
// Directed bench for signed_mult_seq at WIDTH=8 with hand-computed products.
`timescale 1ns/1ps
module tb_signed_mult_seq;

  logic       Clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB, Signed;
  logic [7:0] S;
  logic [7:0] Aval, Bval;
  logic       X, Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  signed_mult_seq #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Signed(Signed), .S(S), .Aval(Aval), .Bval(Bval), .X(X),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    ClearA_LoadB = 1'b1;
    S = v;
    tick();
    ClearA_LoadB = 1'b0;
  endtask

  // Starts a multiply and waits for Done. done_edge is the edge (relative to
  // the start edge k) at which Done is first sampled high.
  task automatic run_mult(input logic [7:0] s, input logic sg, input bit wiggle,
                          output int busy_cycles, output int done_edge);
    int edges;
    Run = 1'b1;
    S = s;
    Signed = sg;
    tick();
    edges = 0;
    busy_cycles = 0;
    while (!Done && edges < 100) begin
      if (Busy) busy_cycles++;
      if (wiggle) begin
        S = 8'($urandom);
        Signed = ~Signed;
        ClearA_LoadB = 1'($urandom);
      end
      tick();
      edges++;
    end
    ClearA_LoadB = 1'b0;
    done_edge = edges + 1;
    if (!Done) begin
      n_fail++;
      $display("FAIL run_timeout: Done=%b after %0d edges, required 1", Done, edges);
    end
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({Aval, Bval, X} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got A=%h B=%h X=%b, required 0", Aval, Bval, X);
    end
    n_checks++;
    if ({Busy, Done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got Busy=%b Done=%b, required 0 0", Busy, Done);
    end
    Reset = 1'b0;
  endtask

  task automatic test_signed_basic();
    int bc, de;
    load_b(8'h07);
    n_checks++;
    if (Bval !== 8'h07) begin
      n_fail++;
      $display("FAIL load_b: got %h, required 07", Bval);
    end
    run_mult(8'hFD, 1'b1, 1'b0, bc, de);
    n_checks++;
    if (bc !== 16) begin
      n_fail++;
      $display("FAIL busy_len: got %0d, required 16", bc);
    end
    n_checks++;
    if (de !== 17) begin
      n_fail++;
      $display("FAIL done_latency: got edge k+%0d, required k+17", de);
    end
    n_checks++;
    if ({Aval, Bval} !== 16'hFFEB || X !== 1'b1) begin
      n_fail++;
      $display("FAIL m3x7: got %h X=%b, required FFEB X=1", {Aval, Bval}, X);
    end
  endtask

  task automatic test_hold_chain();
    int bc, de;
    for (int i = 0; i < 10; i++) begin
      S = 8'(i * 37);
      Signed = i[0];
      ClearA_LoadB = i[1];
      tick();
      n_checks++;
      if (Done !== 1'b1 || {Aval, Bval} !== 16'hFFEB || X !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: got Done=%b P=%h X=%b, required 1 FFEB 1",
                 i, Done, {Aval, Bval}, X);
      end
    end
    ClearA_LoadB = 1'b0;
    release_run();
    n_checks++;
    if ({Busy, Done} !== 2'b00 || {Aval, Bval} !== 16'hFFEB) begin
      n_fail++;
      $display("FAIL hold_release: got Busy=%b Done=%b P=%h, required 0 0 FFEB",
               Busy, Done, {Aval, Bval});
    end
    run_mult(8'h02, 1'b1, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'hFFD6) begin
      n_fail++;
      $display("FAIL chain: got %h, required FFD6", {Aval, Bval});
    end
    release_run();
  endtask

  task automatic test_min_neg();
    int bc, de;
    load_b(8'h80);
    run_mult(8'h80, 1'b1, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'h4000 || X !== 1'b0) begin
      n_fail++;
      $display("FAIL minneg_sq: got %h X=%b, required 4000 X=0", {Aval, Bval}, X);
    end
    release_run();
    load_b(8'h80);
    run_mult(8'h7F, 1'b1, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'hC080 || X !== 1'b1) begin
      n_fail++;
      $display("FAIL maxpos_minneg: got %h X=%b, required C080 X=1", {Aval, Bval}, X);
    end
    release_run();
  endtask

  task automatic test_unsigned();
    int bc, de;
    load_b(8'hFF);
    run_mult(8'hFF, 1'b0, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'hFE01 || X !== 1'b0) begin
      n_fail++;
      $display("FAIL u_ffxff: got %h X=%b, required FE01 X=0", {Aval, Bval}, X);
    end
    release_run();
    load_b(8'hFF);
    run_mult(8'hFF, 1'b1, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'h0001 || X !== 1'b0) begin
      n_fail++;
      $display("FAIL s_ffxff: got %h X=%b, required 0001 X=0", {Aval, Bval}, X);
    end
    release_run();
    load_b(8'h80);
    run_mult(8'hFF, 1'b0, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'h7F80) begin
      n_fail++;
      $display("FAIL u_80xff: got %h, required 7F80", {Aval, Bval});
    end
    release_run();
  endtask

  task automatic test_reset_mid();
    int bc, de;
    load_b(8'h05);
    Run = 1'b1;
    S = 8'h03;
    Signed = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got Busy=%b, required 1", Busy);
    end
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({Aval, Bval, X, Busy, Done} !== 19'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got A=%h B=%h X=%b Busy=%b Done=%b, required all 0",
               Aval, Bval, X, Busy, Done);
    end
    Reset = 1'b0;
    Run = 1'b0;
    load_b(8'h05);
    run_mult(8'h03, 1'b1, 1'b0, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'h000F || de !== 17) begin
      n_fail++;
      $display("FAIL post_reset: got %h at k+%0d, required 000F at k+17", {Aval, Bval}, de);
    end
    release_run();
  endtask

  task automatic test_priority_and_wiggle();
    int bc, de;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    S = 8'h5A;
    tick();
    n_checks++;
    if (Bval !== 8'h5A || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_prio: got B=%h Busy=%b, required 5A 0", Bval, Busy);
    end
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    tick();
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_idle: got Busy=%b, required 0", Busy);
    end
    run_mult(8'h06, 1'b1, 1'b1, bc, de);
    n_checks++;
    if ({Aval, Bval} !== 16'h021C || bc !== 16) begin
      n_fail++;
      $display("FAIL wiggle: got %h busy=%0d, required 021C busy=16", {Aval, Bval}, bc);
    end
    release_run();
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Signed = 1'b1;
    S = 8'h00;
    test_reset();
    test_signed_basic();
    test_hold_chain();
    test_min_neg();
    test_unsigned();
    test_reset_mid();
    test_priority_and_wiggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
